// File: rtl/mdu_pkg.sv
// Shared constants for the iterative multiply/divide unit: op codes, FSM states, datapath width.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_DIVU  = 2'b01;
  localparam logic [1:0] OP_MULT  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mdu_sign_adjust.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign correction.
module mdu_sign_adjust #(
  parameter int unsigned W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout_c
);

  always_comb begin
    dout_c = neg ? (~din + W'(1)) : din;
  end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative 32-step multiply (shift-add) / divide (restoring) unit with HI/LO results.
// Signed MULT/DIV support is compiled in only when MDU_SIGNED_EN is defined.
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned ACC_W = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             is_div_q, is_div_d;
  logic             dbz_pend_q, dbz_pend_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;

  logic             is_div_in;
  logic             dbz_in;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [ACC_W-1:0] iter_next;
  logic [ACC_W-1:0] fin;

  // op[0] selects divide for both the signed and unsigned encodings
  assign is_div_in = op[0];
  assign dbz_in    = is_div_in && (src_b == '0);

`ifdef MDU_SIGNED_EN
  logic             signed_in;
  logic             sa_in;
  logic             sb_in;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic [ACC_W-1:0] prod_adj;
  logic [WIDTH-1:0] quo_adj;
  logic [WIDTH-1:0] rem_adj;

  assign signed_in = (op == OP_MULT) || (op == OP_DIV);
  assign sa_in     = signed_in && src_a[WIDTH-1];
  assign sb_in     = signed_in && src_b[WIDTH-1];

  // A divide by zero keeps the raw dividend so the remainder falls out as src_a bits
  mdu_sign_adjust #(.W(WIDTH)) u_mag_a (.neg(sa_in && !dbz_in), .din(src_a), .dout_c(mag_a));
  mdu_sign_adjust #(.W(WIDTH)) u_mag_b (.neg(sb_in), .din(src_b), .dout_c(mag_b));

  mdu_sign_adjust #(.W(ACC_W)) u_prod (.neg(neg_res_q), .din(iter_next), .dout_c(prod_adj));
  mdu_sign_adjust #(.W(WIDTH)) u_quo  (.neg(neg_res_q), .din(iter_next[WIDTH-1:0]),
                                       .dout_c(quo_adj));
  mdu_sign_adjust #(.W(WIDTH)) u_rem  (.neg(neg_rem_q), .din(iter_next[ACC_W-1:WIDTH]),
                                       .dout_c(rem_adj));

  always_comb begin
    fin = is_div_q ? {rem_adj, quo_adj} : prod_adj;
  end
`else
  logic unused_op_msb;

  assign unused_op_msb = op[1];
  assign mag_a         = src_a;
  assign mag_b         = src_b;

  always_comb begin
    fin = iter_next;
  end
`endif

  // One iteration step: shift-add for multiply, restoring shift-subtract for divide
  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] rem_diff;

  always_comb begin
    mul_sum  = {1'b0, acc_q[ACC_W-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    rem_sh   = {acc_q[ACC_W-1:WIDTH], acc_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, opb_q};
    if (!is_div_q) begin
      iter_next = {mul_sum, acc_q[WIDTH-1:1]};
    end else if (!rem_diff[WIDTH]) begin
      iter_next = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      iter_next = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opb_d      = opb_q;
    is_div_d   = is_div_q;
    dbz_pend_d = dbz_pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;
    dbz_d      = dbz_q;
`ifdef MDU_SIGNED_EN
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d    = RUN;
          busy_d     = 1'b1;
          cnt_d      = '0;
          acc_d      = {WIDTH'(0), mag_a};
          opb_d      = mag_b;
          is_div_d   = is_div_in;
          dbz_pend_d = dbz_in;
          dbz_d      = 1'b0;
`ifdef MDU_SIGNED_EN
          neg_res_d  = sa_in ^ sb_in;
          neg_rem_d  = sa_in;
`endif
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = iter_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          dbz_d   = dbz_pend_q;
          // Divide by zero: quotient all ones, remainder is the untouched dividend
          if (dbz_pend_q) begin
            hi_d = iter_next[ACC_W-1:WIDTH];
            lo_d = '1;
          end else begin
            hi_d = fin[ACC_W-1:WIDTH];
            lo_d = fin[WIDTH-1:0];
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opb_q      <= '0;
      is_div_q   <= 1'b0;
      dbz_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      dbz_q      <= 1'b0;
`ifdef MDU_SIGNED_EN
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opb_q      <= opb_d;
      is_div_q   <= is_div_d;
      dbz_pend_q <= dbz_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      dbz_q      <= dbz_d;
`ifdef MDU_SIGNED_EN
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule
